// File: rtl/decoder_stage.sv
//==============================================================================
// Module   : decoder_stage
// Summary  : Registered RV32I decoder feeding a DEPTH-entry decoded-op FIFO,
//            with JAL redirect, branch notify and illegal-opcode pulses.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module decoder_stage #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int REG_W  = 5,
    parameter int OP_W   = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              iq_valid_in,
    input  logic [INST_W-1:0] iq_inst_in,
    input  logic [ADDR_W-1:0] iq_pc_in,
    output logic              iq_ready_out,
    output logic              iq_rst_out,
    output logic              if_en_out,
    output logic [ADDR_W-1:0] if_addr_out,
    output logic              bp_en_out,
    output logic [ADDR_W-1:0] bp_pc_out,
    output logic [ADDR_W-1:0] bp_target_out,
    output logic              illegal_out,
    output logic              disp_valid_out,
    input  logic              disp_ready_in,
    output logic [REG_W-1:0]  disp_rs_out,
    output logic [REG_W-1:0]  disp_rt_out,
    output logic [REG_W-1:0]  disp_rd_out,
    output logic [INST_W-1:0] disp_imm_out,
    output logic [OP_W-1:0]   disp_op_out,
    output logic [ADDR_W-1:0] disp_pc_out
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_ent_w = OP_W + 3 * REG_W + INST_W + ADDR_W;

    localparam logic [0:0] c_st_run   = 1'b0;
    localparam logic [0:0] c_st_redir = 1'b1;

    localparam logic [OP_W-1:0] c_op_nop   = OP_W'(0),  c_op_lui   = OP_W'(1),  c_op_auipc = OP_W'(2);
    localparam logic [OP_W-1:0] c_op_jal   = OP_W'(3),  c_op_jalr  = OP_W'(4);
    localparam logic [OP_W-1:0] c_op_beq   = OP_W'(5),  c_op_bne   = OP_W'(6),  c_op_blt   = OP_W'(7);
    localparam logic [OP_W-1:0] c_op_bge   = OP_W'(8),  c_op_bltu  = OP_W'(9),  c_op_bgeu  = OP_W'(10);
    localparam logic [OP_W-1:0] c_op_lb    = OP_W'(11), c_op_lh    = OP_W'(12), c_op_lw    = OP_W'(13);
    localparam logic [OP_W-1:0] c_op_lbu   = OP_W'(14), c_op_lhu   = OP_W'(15);
    localparam logic [OP_W-1:0] c_op_sb    = OP_W'(16), c_op_sh    = OP_W'(17), c_op_sw    = OP_W'(18);
    localparam logic [OP_W-1:0] c_op_addi  = OP_W'(19), c_op_slti  = OP_W'(20), c_op_sltiu = OP_W'(21);
    localparam logic [OP_W-1:0] c_op_xori  = OP_W'(22), c_op_ori   = OP_W'(23), c_op_andi  = OP_W'(24);
    localparam logic [OP_W-1:0] c_op_slli  = OP_W'(25), c_op_srli  = OP_W'(26), c_op_srai  = OP_W'(27);
    localparam logic [OP_W-1:0] c_op_add   = OP_W'(28), c_op_sub   = OP_W'(29), c_op_sll   = OP_W'(30);
    localparam logic [OP_W-1:0] c_op_slt   = OP_W'(31), c_op_sltu  = OP_W'(32), c_op_xor   = OP_W'(33);
    localparam logic [OP_W-1:0] c_op_srl   = OP_W'(34), c_op_sra   = OP_W'(35), c_op_or    = OP_W'(36);
    localparam logic [OP_W-1:0] c_op_and   = OP_W'(37);

    logic [0:0]         r_state;
    logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_bp_en, r_illegal;
    logic [ADDR_W-1:0]  r_if_addr, r_bp_pc, r_bp_target;
    logic [c_ent_w-1:0] r_mem [DEPTH];

    logic [OP_W-1:0]   w_op;
    logic [REG_W-1:0]  w_rs, w_rt, w_rd;
    logic [INST_W-1:0] w_imm;
    logic              w_legal, w_is_br, w_is_jal;
    logic [2:0]        w_f3;
    logic              w_alt;
    logic [INST_W-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
    logic [ADDR_W-1:0] w_target;
    logic              w_pop, w_accept, w_push, w_full;
    logic [c_ent_w-1:0] w_entry, w_head;

    assign w_f3     = iq_inst_in[14:12];
    assign w_alt    = iq_inst_in[30];
    assign w_imm_i  = {{(INST_W-12){iq_inst_in[31]}}, iq_inst_in[31:20]};
    assign w_imm_s  = {{(INST_W-12){iq_inst_in[31]}}, iq_inst_in[31:25], iq_inst_in[11:7]};
    assign w_imm_b  = {{(INST_W-12){iq_inst_in[31]}}, iq_inst_in[7], iq_inst_in[30:25], iq_inst_in[11:8], 1'b0};
    assign w_imm_u  = INST_W'({iq_inst_in[31:12], 12'b0});
    assign w_imm_j  = {{(INST_W-20){iq_inst_in[31]}}, iq_inst_in[19:12], iq_inst_in[20], iq_inst_in[30:21], 1'b0};
    assign w_imm_sh = INST_W'(iq_inst_in[24:20]);

    // Field routing: rs/rt/rd/imm stay zero unless the format actually uses them.
    always_comb begin
        w_op = c_op_nop; w_rs = '0; w_rt = '0; w_rd = '0; w_imm = '0;
        w_legal = 1'b0; w_is_br = 1'b0; w_is_jal = 1'b0;
        case (iq_inst_in[6:0])
            7'b0110111: begin w_legal = 1'b1; w_op = c_op_lui;   w_rd = REG_W'(iq_inst_in[11:7]); w_imm = w_imm_u; end
            7'b0010111: begin w_legal = 1'b1; w_op = c_op_auipc; w_rd = REG_W'(iq_inst_in[11:7]); w_imm = w_imm_u; end
            7'b1101111: begin
                w_legal = 1'b1; w_is_jal = 1'b1; w_op = c_op_jal;
                w_rd = REG_W'(iq_inst_in[11:7]); w_imm = w_imm_j;
            end
            7'b1100111: begin
                w_legal = (w_f3 == 3'd0); w_op = c_op_jalr;
                w_rs = REG_W'(iq_inst_in[19:15]); w_rd = REG_W'(iq_inst_in[11:7]); w_imm = w_imm_i;
            end
            7'b1100011: begin
                w_is_br = 1'b1; w_legal = 1'b1;
                w_rs = REG_W'(iq_inst_in[19:15]); w_rt = REG_W'(iq_inst_in[24:20]); w_imm = w_imm_b;
                case (w_f3)
                    3'd0: w_op = c_op_beq;
                    3'd1: w_op = c_op_bne;
                    3'd4: w_op = c_op_blt;
                    3'd5: w_op = c_op_bge;
                    3'd6: w_op = c_op_bltu;
                    3'd7: w_op = c_op_bgeu;
                    default: w_legal = 1'b0;
                endcase
            end
            7'b0000011: begin
                w_legal = 1'b1;
                w_rs = REG_W'(iq_inst_in[19:15]); w_rd = REG_W'(iq_inst_in[11:7]); w_imm = w_imm_i;
                case (w_f3)
                    3'd0: w_op = c_op_lb;
                    3'd1: w_op = c_op_lh;
                    3'd2: w_op = c_op_lw;
                    3'd4: w_op = c_op_lbu;
                    3'd5: w_op = c_op_lhu;
                    default: w_legal = 1'b0;
                endcase
            end
            7'b0100011: begin
                w_legal = 1'b1;
                w_rs = REG_W'(iq_inst_in[19:15]); w_rt = REG_W'(iq_inst_in[24:20]); w_imm = w_imm_s;
                case (w_f3)
                    3'd0: w_op = c_op_sb;
                    3'd1: w_op = c_op_sh;
                    3'd2: w_op = c_op_sw;
                    default: w_legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                w_legal = 1'b1;
                w_rs = REG_W'(iq_inst_in[19:15]); w_rd = REG_W'(iq_inst_in[11:7]); w_imm = w_imm_i;
                case (w_f3)
                    3'd0: w_op = c_op_addi;
                    3'd1: begin w_op = c_op_slli; w_imm = w_imm_sh; end
                    3'd2: w_op = c_op_slti;
                    3'd3: w_op = c_op_sltiu;
                    3'd4: w_op = c_op_xori;
                    3'd5: begin w_op = w_alt ? c_op_srai : c_op_srli; w_imm = w_imm_sh; end
                    3'd6: w_op = c_op_ori;
                    default: w_op = c_op_andi;
                endcase
            end
            7'b0110011: begin
                w_legal = 1'b1;
                w_rs = REG_W'(iq_inst_in[19:15]); w_rt = REG_W'(iq_inst_in[24:20]); w_rd = REG_W'(iq_inst_in[11:7]);
                case (w_f3)
                    3'd0: w_op = w_alt ? c_op_sub : c_op_add;
                    3'd1: w_op = c_op_sll;
                    3'd2: w_op = c_op_slt;
                    3'd3: w_op = c_op_sltu;
                    3'd4: w_op = c_op_xor;
                    3'd5: w_op = w_alt ? c_op_sra : c_op_srl;
                    3'd6: w_op = c_op_or;
                    default: w_op = c_op_and;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_target = iq_pc_in + ADDR_W'(w_imm);
    assign w_entry  = {w_op, w_rs, w_rt, w_rd, w_imm, iq_pc_in};
    assign w_head   = r_mem[r_rd_ptr];

    assign disp_valid_out = (r_count != '0);
    assign w_full   = (r_count == c_cnt_w'(DEPTH));
    assign w_pop    = rdy_in & disp_valid_out & disp_ready_in;
    // A frozen stage must not take input, so the global enable also gates ready.
    assign iq_ready_out = rdy_in & (r_state == c_st_run) & (~w_full | w_pop) & ~flush_in;
    assign w_accept = iq_valid_in & iq_ready_out;
    assign w_push   = w_accept & w_legal;

    // Pulses are masked while frozen (and replayed on release) or cancelled by flush.
    assign if_en_out     = (r_state == c_st_redir) & rdy_in & ~flush_in;
    assign iq_rst_out    = if_en_out;
    assign bp_en_out     = r_bp_en & rdy_in & ~flush_in;
    assign illegal_out   = r_illegal & rdy_in & ~flush_in;
    assign if_addr_out   = r_if_addr;
    assign bp_pc_out     = r_bp_pc;
    assign bp_target_out = r_bp_target;

    assign disp_op_out  = disp_valid_out ? w_head[c_ent_w-1 -: OP_W] : c_op_nop;
    assign disp_rs_out  = disp_valid_out ? w_head[ADDR_W+INST_W+2*REG_W +: REG_W] : '0;
    assign disp_rt_out  = disp_valid_out ? w_head[ADDR_W+INST_W+REG_W +: REG_W] : '0;
    assign disp_rd_out  = disp_valid_out ? w_head[ADDR_W+INST_W +: REG_W] : '0;
    assign disp_imm_out = disp_valid_out ? w_head[ADDR_W +: INST_W] : '0;
    assign disp_pc_out  = disp_valid_out ? w_head[ADDR_W-1:0] : '0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= c_st_run;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_bp_en     <= 1'b0;
            r_illegal   <= 1'b0;
            r_if_addr   <= '0;
            r_bp_pc     <= '0;
            r_bp_target <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_state   <= c_st_run;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_bp_en   <= 1'b0;
                r_illegal <= 1'b0;
            end else begin
                r_bp_en   <= w_push & w_is_br;
                r_illegal <= w_accept & ~w_legal;
                if (r_state == c_st_redir) begin
                    r_state <= c_st_run;
                end else if (w_push & w_is_jal) begin
                    r_state   <= c_st_redir;
                    r_if_addr <= w_target;
                end
                if (w_push & w_is_br) begin
                    r_bp_pc     <= iq_pc_in;
                    r_bp_target <= w_target;
                end
                if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && w_push) r_mem[r_wr_ptr] <= w_entry;
    end

endmodule

`default_nettype wire

// File: tb/tb_decoder_stage.sv
//==============================================================================
// Module   : tb_decoder_stage
// Summary  : Self-checking bench for decoder_stage: vector table, directed
//            FIFO/flush/freeze sequences and a randomized queue-based model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_decoder_stage;

    localparam int DEPTH = 4;

    localparam int OP_NOP = 0, OP_LUI = 1, OP_AUIPC = 2, OP_JAL = 3, OP_JALR = 4;
    localparam int OP_BEQ = 5, OP_BNE = 6, OP_BLT = 7, OP_BGE = 8, OP_BLTU = 9, OP_BGEU = 10;
    localparam int OP_LB = 11, OP_LH = 12, OP_LW = 13, OP_LBU = 14, OP_LHU = 15;
    localparam int OP_SB = 16, OP_SH = 17, OP_SW = 18;
    localparam int OP_ADDI = 19, OP_SLTI = 20, OP_SLTIU = 21, OP_XORI = 22, OP_ORI = 23, OP_ANDI = 24;
    localparam int OP_SLLI = 25, OP_SRLI = 26, OP_SRAI = 27;
    localparam int OP_ADD = 28, OP_SUB = 29, OP_SLL = 30, OP_SLT = 31, OP_SLTU = 32, OP_XOR = 33;
    localparam int OP_SRL = 34, OP_SRA = 35, OP_OR = 36, OP_AND = 37;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, iq_valid, disp_ready;
    logic [31:0] iq_inst, iq_pc;
    logic        iq_ready_out, iq_rst_out, if_en_out, bp_en_out, illegal_out, disp_valid_out;
    logic [31:0] if_addr_out, bp_pc_out, bp_target_out, disp_imm_out, disp_pc_out;
    logic [4:0]  disp_rs_out, disp_rt_out, disp_rd_out;
    logic [5:0]  disp_op_out;

    always #5 clk = ~clk;

    decoder_stage #(.ADDR_W(32), .INST_W(32), .REG_W(5), .OP_W(6), .DEPTH(DEPTH)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
        .iq_valid_in(iq_valid), .iq_inst_in(iq_inst), .iq_pc_in(iq_pc),
        .iq_ready_out(iq_ready_out), .iq_rst_out(iq_rst_out),
        .if_en_out(if_en_out), .if_addr_out(if_addr_out),
        .bp_en_out(bp_en_out), .bp_pc_out(bp_pc_out), .bp_target_out(bp_target_out),
        .illegal_out(illegal_out), .disp_valid_out(disp_valid_out), .disp_ready_in(disp_ready),
        .disp_rs_out(disp_rs_out), .disp_rt_out(disp_rt_out), .disp_rd_out(disp_rd_out),
        .disp_imm_out(disp_imm_out), .disp_op_out(disp_op_out), .disp_pc_out(disp_pc_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        rdy = 1'b1; flush = 1'b0; iq_valid = 1'b0; disp_ready = 1'b0;
        iq_inst = 32'h0; iq_pc = 32'h0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] addi(input int k);
        logic [11:0] v;
        v = 12'(k);
        return {v, 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit          legal;
        int          op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm, pc;
    } ent_t;

    int br_tab [8] = '{OP_BEQ, OP_BNE, -1, -1, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    int ld_tab [8] = '{OP_LB, OP_LH, OP_LW, -1, OP_LBU, OP_LHU, -1, -1};
    int st_tab [8] = '{OP_SB, OP_SH, OP_SW, -1, -1, -1, -1, -1};
    int oi_tab [8] = '{OP_ADDI, OP_SLLI, OP_SLTI, OP_SLTIU, OP_XORI, OP_SRLI, OP_ORI, OP_ANDI};
    int op_tab [8] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};

    function automatic ent_t model_decode(input logic [31:0] i, input logic [31:0] pc);
        ent_t e;
        int f3;
        logic [31:0] sgn, imm_i, imm_s, imm_b, imm_j;
        f3    = int'(i[14:12]);
        sgn   = 32'($signed(i) >>> 31);
        imm_i = 32'($signed(i) >>> 20);
        imm_s = (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
        imm_b = (sgn << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        imm_j = (sgn << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
        e.legal = 1'b1; e.op = OP_NOP; e.rs = 5'd0; e.rt = 5'd0; e.rd = 5'd0; e.imm = 32'd0; e.pc = pc;
        case (i[6:0])
            7'h37: begin e.op = OP_LUI;   e.rd = i[11:7]; e.imm = i & 32'hFFFFF000; end
            7'h17: begin e.op = OP_AUIPC; e.rd = i[11:7]; e.imm = i & 32'hFFFFF000; end
            7'h6F: begin e.op = OP_JAL;   e.rd = i[11:7]; e.imm = imm_j; end
            7'h67: begin e.op = OP_JALR;  e.rs = i[19:15]; e.rd = i[11:7]; e.imm = imm_i; e.legal = (f3 == 0); end
            7'h63: begin e.op = br_tab[f3]; e.rs = i[19:15]; e.rt = i[24:20]; e.imm = imm_b; end
            7'h03: begin e.op = ld_tab[f3]; e.rs = i[19:15]; e.rd = i[11:7]; e.imm = imm_i; end
            7'h23: begin e.op = st_tab[f3]; e.rs = i[19:15]; e.rt = i[24:20]; e.imm = imm_s; end
            7'h13: begin
                e.op = oi_tab[f3]; e.rs = i[19:15]; e.rd = i[11:7]; e.imm = imm_i;
                if (f3 == 1 || f3 == 5) e.imm = 32'(i[24:20]);
                if (f3 == 5 && i[30]) e.op = OP_SRAI;
            end
            7'h33: begin
                e.op = op_tab[f3]; e.rs = i[19:15]; e.rt = i[24:20]; e.rd = i[11:7];
                if (f3 == 0 && i[30]) e.op = OP_SUB;
                if (f3 == 5 && i[30]) e.op = OP_SRA;
            end
            default: e.legal = 1'b0;
        endcase
        if (e.op < 0) e.legal = 1'b0;
        if (!e.legal) e.op = OP_NOP;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0B, 7'h00};
        logic [31:0] r;
        int p;
        r = $urandom;
        p = $urandom_range(0, 10);
        r[6:0] = (p == 10) ? 7'($urandom) : ops[p];
        return r;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] inst, pc;
        bit          ill;
        int          op, rs, rt, rd;
        logic [31:0] imm;
        bit          br, jal;
        logic [31:0] tgt;
    } vec_t;

    vec_t vt [11];

    ent_t        q [$];
    bit          m_redir, m_bp_en, m_ill;
    logic [31:0] m_if_addr, m_bp_pc, m_bp_tgt;

    initial begin
        vt[0]  = '{32'hFFF10093, 32'h100,  1'b0, OP_ADDI, 2, 0, 1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{32'hFE208CE3, 32'h200,  1'b0, OP_BEQ,  1, 2, 0, 32'hFFFFFFF8, 1'b1, 1'b0, 32'h1F8};
        vt[2]  = '{32'h001000EF, 32'h1000, 1'b0, OP_JAL,  0, 0, 1, 32'h00000800, 1'b0, 1'b1, 32'h1800};
        vt[3]  = '{32'h005201B3, 32'h300,  1'b0, OP_ADD,  4, 5, 3, 32'h0,        1'b0, 1'b0, 32'h0};
        vt[4]  = '{32'h405201B3, 32'h304,  1'b0, OP_SUB,  4, 5, 3, 32'h0,        1'b0, 1'b0, 32'h0};
        vt[5]  = '{32'h40315093, 32'h308,  1'b0, OP_SRAI, 2, 0, 1, 32'h3,        1'b0, 1'b0, 32'h0};
        vt[6]  = '{32'hABCDE2B7, 32'h30C,  1'b0, OP_LUI,  0, 0, 5, 32'hABCDE000, 1'b0, 1'b0, 32'h0};
        vt[7]  = '{32'hFE63AE23, 32'h310,  1'b0, OP_SW,   7, 6, 0, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0};
        vt[8]  = '{32'h0104A403, 32'h314,  1'b0, OP_LW,   9, 0, 8, 32'h10,       1'b0, 1'b0, 32'h0};
        vt[9]  = '{32'h0000000B, 32'h318,  1'b1, OP_NOP,  0, 0, 0, 32'h0,        1'b0, 1'b0, 32'h0};
        vt[10] = '{32'h00003003, 32'h31C,  1'b1, OP_NOP,  0, 0, 0, 32'h0,        1'b0, 1'b0, 32'h0};

        rst = 1'b1;
        do_reset();
        #1;
        chk("rst_valid", disp_valid_out, 0);
        chk("rst_op", disp_op_out, OP_NOP);
        chk("rst_imm", disp_imm_out, 0);
        chk("rst_pc", disp_pc_out, 0);
        chk("rst_if_en", if_en_out, 0);
        chk("rst_iq_rst", iq_rst_out, 0);
        chk("rst_if_addr", if_addr_out, 0);
        chk("rst_bp_en", bp_en_out, 0);
        chk("rst_bp_pc", bp_pc_out, 0);
        chk("rst_bp_target", bp_target_out, 0);
        chk("rst_illegal", illegal_out, 0);
        chk("rst_ready", iq_ready_out, 1);

        for (int k = 0; k < 11; k++) begin
            iq_inst = vt[k].inst; iq_pc = vt[k].pc; iq_valid = 1'b1; disp_ready = 1'b0;
            #1 chk($sformatf("vec%0d_ready", k), iq_ready_out, 1);
            tick();
            iq_valid = 1'b0;
            #1;
            if (vt[k].ill) begin
                chk($sformatf("vec%0d_illegal", k), illegal_out, 1);
                chk($sformatf("vec%0d_valid", k), disp_valid_out, 0);
            end else begin
                chk($sformatf("vec%0d_illegal", k), illegal_out, 0);
                chk($sformatf("vec%0d_valid", k), disp_valid_out, 1);
                chk($sformatf("vec%0d_op", k), disp_op_out, vt[k].op);
                chk($sformatf("vec%0d_rs", k), disp_rs_out, vt[k].rs);
                chk($sformatf("vec%0d_rt", k), disp_rt_out, vt[k].rt);
                chk($sformatf("vec%0d_rd", k), disp_rd_out, vt[k].rd);
                chk($sformatf("vec%0d_imm", k), disp_imm_out, vt[k].imm);
                chk($sformatf("vec%0d_pc", k), disp_pc_out, vt[k].pc);
            end
            chk($sformatf("vec%0d_bp_en", k), bp_en_out, vt[k].br);
            if (vt[k].br) begin
                chk($sformatf("vec%0d_bp_pc", k), bp_pc_out, vt[k].pc);
                chk($sformatf("vec%0d_bp_target", k), bp_target_out, vt[k].tgt);
            end
            chk($sformatf("vec%0d_if_en", k), if_en_out, vt[k].jal);
            chk($sformatf("vec%0d_iq_rst", k), iq_rst_out, vt[k].jal);
            if (vt[k].jal) begin
                chk($sformatf("vec%0d_if_addr", k), if_addr_out, vt[k].tgt);
                chk($sformatf("vec%0d_redir_ready", k), iq_ready_out, 0);
            end
            disp_ready = 1'b1;
            tick();
            disp_ready = 1'b0;
            #1;
            chk($sformatf("vec%0d_after_valid", k), disp_valid_out, 0);
            chk($sformatf("vec%0d_after_pulse", k), {if_en_out, iq_rst_out, bp_en_out, illegal_out}, 0);
            chk($sformatf("vec%0d_after_ready", k), iq_ready_out, 1);
        end

        // Full FIFO, then simultaneous push and pop keeps it full and ordered.
        idle();
        for (int k = 1; k <= DEPTH; k++) begin
            iq_inst = addi(k); iq_pc = 32'h400 + 32'(4 * k); iq_valid = 1'b1;
            tick();
        end
        iq_inst = addi(DEPTH + 1); iq_pc = 32'h500;
        #1 chk("full_ready", iq_ready_out, 0);
        disp_ready = 1'b1;
        #1 chk("full_pushpop_ready", iq_ready_out, 1);
        tick();
        iq_valid = 1'b0; disp_ready = 1'b0;
        #1;
        chk("full_still_full", iq_ready_out, 0);
        for (int k = 2; k <= DEPTH + 1; k++) begin
            chk($sformatf("full_order%0d", k), disp_imm_out, 32'(k));
            disp_ready = 1'b1;
            tick();
            disp_ready = 1'b0;
            #1;
        end
        chk("full_drained", disp_valid_out, 0);

        // Full FIFO with a pending redirect, cancelled by flush.
        idle();
        for (int k = 1; k < DEPTH; k++) begin
            iq_inst = addi(k); iq_valid = 1'b1;
            tick();
        end
        iq_inst = 32'h001000EF; iq_pc = 32'h1000;
        tick();
        iq_valid = 1'b0;
        #1 chk("flush_pending_if_en", if_en_out, 1);
        flush = 1'b1;
        #1;
        chk("flush_if_en", if_en_out, 0);
        chk("flush_iq_rst", iq_rst_out, 0);
        chk("flush_ready", iq_ready_out, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_valid", disp_valid_out, 0);
        chk("flush_no_if_en", if_en_out, 0);
        chk("flush_ready_after", iq_ready_out, 1);
        iq_inst = addi(7); iq_valid = 1'b1;
        tick();
        iq_valid = 1'b0;
        #1;
        chk("flush_reaccept_valid", disp_valid_out, 1);
        chk("flush_reaccept_imm", disp_imm_out, 32'd7);
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;

        // rdy_in low freezes FIFO, redirect and handshakes.
        idle();
        iq_inst = addi(3); iq_valid = 1'b1; tick();
        iq_inst = addi(4); tick();
        iq_inst = 32'h001000EF; iq_pc = 32'h2000; tick();
        rdy = 1'b0; disp_ready = 1'b1; iq_inst = addi(9);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("frz%0d_if_en", c), if_en_out, 0);
            chk($sformatf("frz%0d_valid", c), disp_valid_out, 1);
            chk($sformatf("frz%0d_head", c), disp_imm_out, 32'd3);
            tick();
        end
        rdy = 1'b1; iq_valid = 1'b0; disp_ready = 1'b0;
        #1;
        chk("frz_release_if_en", if_en_out, 1);
        chk("frz_release_iq_rst", iq_rst_out, 1);
        chk("frz_release_if_addr", if_addr_out, 32'h2800);
        tick();
        #1 chk("frz_pulse_once", if_en_out, 0);
        chk("frz_head0", disp_imm_out, 32'd3);
        disp_ready = 1'b1; tick(); #1;
        chk("frz_head1", disp_imm_out, 32'd4);
        tick(); #1;
        chk("frz_head2_op", disp_op_out, OP_JAL);
        chk("frz_head2_imm", disp_imm_out, 32'h800);
        tick(); #1;
        chk("frz_empty", disp_valid_out, 0);
        disp_ready = 1'b0;

        // Randomized traffic against the queue model.
        do_reset();
        q.delete();
        m_redir = 1'b0; m_bp_en = 1'b0; m_ill = 1'b0;
        m_if_addr = 32'h0; m_bp_pc = 32'h0; m_bp_tgt = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit   pop, e_ready, acc, gate;
            ent_t d;
            rdy        = ($urandom_range(0, 9) != 0);
            flush      = ($urandom_range(0, 24) == 0);
            iq_valid   = ($urandom_range(0, 9) < 7);
            disp_ready = ($urandom_range(0, 9) < 6);
            iq_inst    = rand_inst();
            iq_pc      = $urandom & 32'hFFFF_FFFC;
            #1;
            pop     = rdy && (q.size() > 0) && disp_ready;
            e_ready = rdy && !m_redir && ((q.size() < DEPTH) || pop) && !flush;
            gate    = rdy && !flush;
            chk("rnd_ready", iq_ready_out, e_ready);
            chk("rnd_valid", disp_valid_out, q.size() > 0);
            if (q.size() > 0) begin
                chk("rnd_op", disp_op_out, q[0].op);
                chk("rnd_regs", {disp_rs_out, disp_rt_out, disp_rd_out}, {q[0].rs, q[0].rt, q[0].rd});
                chk("rnd_imm", disp_imm_out, q[0].imm);
                chk("rnd_pc", disp_pc_out, q[0].pc);
            end else begin
                chk("rnd_empty_op", disp_op_out, OP_NOP);
            end
            chk("rnd_if_en", {if_en_out, iq_rst_out}, {2{m_redir && gate}});
            chk("rnd_if_addr", if_addr_out, m_if_addr);
            chk("rnd_bp_en", bp_en_out, m_bp_en && gate);
            chk("rnd_bp", {bp_pc_out, bp_target_out}, {m_bp_pc, m_bp_tgt});
            chk("rnd_illegal", illegal_out, m_ill && gate);
            if (rdy) begin
                if (flush) begin
                    q.delete();
                    m_redir = 1'b0; m_bp_en = 1'b0; m_ill = 1'b0;
                end else begin
                    if (pop) void'(q.pop_front());
                    acc     = iq_valid && e_ready;
                    d       = model_decode(iq_inst, iq_pc);
                    m_redir = acc && d.legal && (d.op == OP_JAL);
                    m_ill   = acc && !d.legal;
                    m_bp_en = acc && d.legal && (d.op >= OP_BEQ) && (d.op <= OP_BGEU);
                    if (m_bp_en) begin m_bp_pc = iq_pc; m_bp_tgt = iq_pc + d.imm; end
                    if (m_redir) m_if_addr = iq_pc + d.imm;
                    if (acc && d.legal) q.push_back(d);
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
